// File: rtl/branch_resolve_unit.sv
// Resolves branches in ID against the prediction carried from IF, drives refetch/redirect,
// and queues predictor training updates in a small FIFO alongside branch/mispredict statistics.
module branch_resolve_unit #(
  parameter int PC_W    = 8,
  parameter int PC_STEP = 1,
  parameter int QDEPTH  = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  PC_IF,
  input  logic [PC_W-1:0]  PC_pre_IF,
  input  logic             taken_IF,
  input  logic             hit_IF,
  input  logic             FD_stall,
  input  logic             inst_valid,
  input  logic             is_branch_ID,
  input  logic             Branch_ctrl_ID,
  input  logic [PC_W-1:0]  jump_PC_ID,
  output logic             refetch,
  output logic [PC_W-1:0]  redirect_PC,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_PC,
  output logic             upd_taken,
  output logic [PC_W-1:0]  upd_target,
  input  logic             upd_ready,
  output logic             upd_overflow,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(QDEPTH);

  logic [PC_W-1:0] PC_ID;
  logic [PC_W-1:0] pred_tgt_ID;
  logic            pred_taken_ID;
  logic            pred_hit_ID;
  logic            valid_ID;

  logic resolve;
  logic mispredict;
  logic enq;
  logic deq;
  logic full;
  logic push;

  logic [PC_W-1:0] fifo_pc     [QDEPTH];
  logic            fifo_taken  [QDEPTH];
  logic [PC_W-1:0] fifo_target [QDEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  // A refetch squashes the wrong-path fetch by loading a bubble into ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_ID         <= '0;
      pred_tgt_ID   <= '0;
      pred_taken_ID <= 1'b0;
      pred_hit_ID   <= 1'b0;
      valid_ID      <= 1'b0;
    end else if (!FD_stall) begin
      if (refetch) begin
        PC_ID         <= '0;
        pred_tgt_ID   <= '0;
        pred_taken_ID <= 1'b0;
        pred_hit_ID   <= 1'b0;
        valid_ID      <= 1'b0;
      end else begin
        PC_ID         <= PC_IF;
        pred_tgt_ID   <= PC_pre_IF;
        pred_taken_ID <= taken_IF;
        pred_hit_ID   <= hit_IF;
        valid_ID      <= 1'b1;
      end
    end
  end

  assign resolve    = valid_ID & inst_valid & is_branch_ID & ~FD_stall;
  assign mispredict = resolve & ((pred_taken_ID != Branch_ctrl_ID) |
                                 (pred_taken_ID & Branch_ctrl_ID & (pred_tgt_ID != jump_PC_ID)));
  assign refetch    = mispredict;

  always_comb begin
    redirect_PC = '0;
    if (mispredict) begin
      redirect_PC = Branch_ctrl_ID ? jump_PC_ID : PC_ID + PC_W'(PC_STEP);
    end
  end

  // Not-taken branches that missed in the predictor carry nothing worth training.
  assign enq       = resolve & (Branch_ctrl_ID | pred_hit_ID);
  assign upd_valid = (count != '0);
  assign deq       = upd_valid & upd_ready;
  assign full      = (count == FULL_COUNT);
  assign push      = enq & (~full | deq);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_pc[i]     <= '0;
        fifo_taken[i]  <= 1'b0;
        fifo_target[i] <= '0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr]     <= PC_ID;
      fifo_taken[wr_ptr]  <= Branch_ctrl_ID;
      fifo_target[wr_ptr] <= jump_PC_ID;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (deq)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign upd_PC     = fifo_pc[rd_ptr];
  assign upd_taken  = fifo_taken[rd_ptr];
  assign upd_target = fifo_target[rd_ptr];

  // Overflow stays set once any training update has been lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_overflow <= 1'b0;
    end else if (enq & full & ~deq) begin
      upd_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && branch_cnt != '1)     branch_cnt  <= branch_cnt + 1'b1;
      if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int PC_W   = 8;
  localparam int QDEPTH = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [PC_W-1:0]  PC_IF, PC_pre_IF, jump_PC_ID;
  logic             taken_IF, hit_IF, FD_stall, inst_valid, is_branch_ID, Branch_ctrl_ID, upd_ready;
  logic             refetch, upd_valid, upd_taken, upd_overflow;
  logic [PC_W-1:0]  redirect_PC, upd_PC, upd_target;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(PC_W), .PC_STEP(1), .QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .PC_IF(PC_IF), .PC_pre_IF(PC_pre_IF), .taken_IF(taken_IF), .hit_IF(hit_IF),
    .FD_stall(FD_stall), .inst_valid(inst_valid), .is_branch_ID(is_branch_ID),
    .Branch_ctrl_ID(Branch_ctrl_ID), .jump_PC_ID(jump_PC_ID),
    .refetch(refetch), .redirect_PC(redirect_PC),
    .upd_valid(upd_valid), .upd_PC(upd_PC), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_ready(upd_ready), .upd_overflow(upd_overflow),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic [7:0] pc;
    logic       taken;
    logic [7:0] target;
  } entry_t;

  entry_t     model_q[$];
  logic       m_valid, m_taken, m_hit, m_ovf;
  logic [7:0] m_pc, m_tgt;
  int         m_branches, m_mispreds;
  int         tests = 0;
  int         fails = 0;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_taken = 1'b0; m_hit = 1'b0; m_ovf = 1'b0;
    m_pc = '0; m_tgt = '0; m_branches = 0; m_mispreds = 0;
    model_q.delete();
  endtask

  task automatic set_idle_inputs();
    PC_IF = '0; PC_pre_IF = '0; taken_IF = 1'b0; hit_IF = 1'b0;
    FD_stall = 1'b1; inst_valid = 1'b0; is_branch_ID = 1'b0;
    Branch_ctrl_ID = 1'b0; jump_PC_ID = '0; upd_ready = 1'b0;
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model past the posedge.
  task automatic apply_stimulus(input logic [7:0] pc, input logic [7:0] pre, input logic tk, input logic ht,
                                input logic st, input logic iv, input logic br, input logic bc,
                                input logic [7:0] jpc, input logic rdy);
    logic       res, mis, enq_m, deq_m;
    logic [7:0] exp_redir;
    entry_t     e;
    @(negedge clk);
    PC_IF = pc; PC_pre_IF = pre; taken_IF = tk; hit_IF = ht; FD_stall = st;
    inst_valid = iv; is_branch_ID = br; Branch_ctrl_ID = bc; jump_PC_ID = jpc; upd_ready = rdy;
    #1;
    res = m_valid && iv && br && !st;
    mis = res && ((m_taken != bc) || (m_taken && bc && (m_tgt != jpc)));
    exp_redir = !mis ? 8'h00 : (bc ? jpc : 8'(m_pc + 8'd1));
    check_output("refetch", refetch, mis);
    check_output("redirect_PC", redirect_PC, exp_redir);
    check_output("upd_valid", upd_valid, model_q.size() != 0);
    if (model_q.size() != 0) begin
      check_output("upd_PC", upd_PC, model_q[0].pc);
      check_output("upd_taken", upd_taken, model_q[0].taken);
      if (model_q[0].taken) check_output("upd_target", upd_target, model_q[0].target);
    end
    check_output("upd_overflow", upd_overflow, m_ovf);
    check_output("branch_cnt", branch_cnt, m_branches);
    check_output("mispred_cnt", mispred_cnt, m_mispreds);

    deq_m = (model_q.size() != 0) && rdy;
    enq_m = res && (bc || m_hit);
    if (deq_m) void'(model_q.pop_front());
    if (enq_m) begin
      if (model_q.size() < QDEPTH) begin
        e.pc = m_pc; e.taken = bc; e.target = jpc;
        model_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (res && m_branches < 65535) m_branches++;
    if (mis && m_mispreds < 65535) m_mispreds++;
    if (!st) begin
      if (mis) begin
        m_valid = 1'b0; m_pc = '0; m_tgt = '0; m_taken = 1'b0; m_hit = 1'b0;
      end else begin
        m_valid = 1'b1; m_pc = pc; m_tgt = pre; m_taken = tk; m_hit = ht;
      end
    end
  endtask

  task automatic idle_step(input logic rdy);
    apply_stimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, rdy);
  endtask

  initial begin
    logic [7:0] rpc, rpre, rjpc;
    logic       rtk, rht, rst_in, riv, rbr, rbc, rrdy;

    // Reset: every output must read zero.
    set_idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_output("reset refetch", refetch, 0);
    check_output("reset redirect_PC", redirect_PC, 0);
    check_output("reset upd_valid", upd_valid, 0);
    check_output("reset upd_PC", upd_PC, 0);
    check_output("reset upd_taken", upd_taken, 0);
    check_output("reset upd_target", upd_target, 0);
    check_output("reset upd_overflow", upd_overflow, 0);
    check_output("reset branch_cnt", branch_cnt, 0);
    check_output("reset mispred_cnt", mispred_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Correctly predicted taken branch.
    apply_stimulus(8'h10, 8'h20, 1, 1, 0, 0, 0, 0, 8'h00, 1);
    apply_stimulus(8'h11, 8'h00, 0, 0, 0, 1, 1, 1, 8'h20, 1);
    check_output("t1 refetch", refetch, 0);
    idle_step(1);
    check_output("t1 branch_cnt", branch_cnt, 1);
    check_output("t1 upd_valid", upd_valid, 1);
    check_output("t1 upd_PC", upd_PC, 8'h10);
    check_output("t1 upd_target", upd_target, 8'h20);

    // Predicted taken, resolved not-taken.
    apply_stimulus(8'h10, 8'h20, 1, 1, 0, 0, 0, 0, 8'h00, 1);
    apply_stimulus(8'h30, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 1);
    check_output("t2 refetch", refetch, 1);
    check_output("t2 redirect_PC", redirect_PC, 8'h11);
    apply_stimulus(8'h31, 8'h00, 0, 0, 0, 1, 1, 1, 8'h05, 1);
    check_output("t2 bubble refetch", refetch, 0);
    check_output("t2 mispred_cnt", mispred_cnt, 1);
    check_output("t2 upd_taken", upd_taken, 0);

    // Wrong target, then a not-taken miss that must not train.
    apply_stimulus(8'h10, 8'h20, 1, 1, 0, 0, 0, 0, 8'h00, 1);
    apply_stimulus(8'h40, 8'h00, 0, 0, 0, 1, 1, 1, 8'h30, 1);
    check_output("t3 refetch", refetch, 1);
    check_output("t3 redirect_PC", redirect_PC, 8'h30);
    apply_stimulus(8'h40, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    apply_stimulus(8'h41, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 1);
    check_output("t3 miss refetch", refetch, 0);
    apply_stimulus(8'h10, 8'h20, 1, 1, 0, 0, 0, 0, 8'h00, 1);
    check_output("t3 no enqueue", upd_valid, 0);
    check_output("t3 branch_cnt", branch_cnt, 4);
    check_output("t3 mispred_cnt", mispred_cnt, 2);

    // Stall over a mispredicting branch.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(8'(8'h50 + i), 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 1);
      check_output("t4 stall refetch", refetch, 0);
      check_output("t4 stall branch_cnt", branch_cnt, 4);
    end
    apply_stimulus(8'h50, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 1);
    check_output("t4 release refetch", refetch, 1);
    check_output("t4 release redirect_PC", redirect_PC, 8'h11);
    apply_stimulus(8'h51, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 1);
    check_output("t4 one-shot refetch", refetch, 0);
    check_output("t4 mispred_cnt", mispred_cnt, 3);

    // Fill past capacity with the consumer stalled, then drain in order.
    apply_stimulus(8'h60, 8'h70, 1, 1, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(8'(8'h61 + i), 8'(8'h71 + i), 1, 1, 0, 1, 1, 1, 8'(8'h70 + i), 0);
    end
    idle_step(0);
    check_output("t5 upd_overflow", upd_overflow, 1);
    check_output("t5 head held", upd_PC, 8'h60);
    for (int i = 0; i < 4; i++) begin
      idle_step(1);
      check_output("t5 drain order", upd_PC, 8'(8'h60 + i));
    end
    idle_step(1);
    check_output("t5 drained", upd_valid, 0);
    check_output("t5 overflow sticky", upd_overflow, 1);

    // Asynchronous reset with queued entries and a live refetch.
    apply_stimulus(8'h80, 8'h90, 1, 1, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(8'(8'h81 + i), 8'(8'h91 + i), 1, 1, 0, 1, 1, 1, 8'(8'h90 + i), 0);
    end
    apply_stimulus(8'h00, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 0);
    check_output("t6 pre refetch", refetch, 1);
    check_output("t6 pre upd_valid", upd_valid, 1);
    #1 rst = 1'b0;
    #1;
    check_output("t6 async upd_valid", upd_valid, 0);
    check_output("t6 async refetch", refetch, 0);
    check_output("t6 async redirect_PC", redirect_PC, 0);
    check_output("t6 async branch_cnt", branch_cnt, 0);
    check_output("t6 async mispred_cnt", mispred_cnt, 0);
    check_output("t6 async upd_overflow", upd_overflow, 0);
    model_reset();
    set_idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rpc    = 8'($urandom);
      rpre   = 8'($urandom_range(0, 3) * 16);
      rtk    = 1'($urandom_range(0, 1));
      rht    = 1'($urandom_range(0, 1));
      rst_in = ($urandom_range(0, 4) == 0);
      riv    = ($urandom_range(0, 3) != 0);
      rbr    = 1'($urandom_range(0, 1));
      rbc    = 1'($urandom_range(0, 1));
      rjpc   = ($urandom_range(0, 1) == 1) ? m_tgt : 8'($urandom);
      rrdy   = ($urandom_range(0, 2) != 0);
      apply_stimulus(rpc, rpre, rtk, rht, rst_in, riv, rbr, rbc, rjpc, rrdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- ID-stage consumer of the IF-stage branch predictor's outputs.
- Carries each fetch's prediction (hit, taken, target) into ID and compares it with the resolved branch outcome.
- Drives refetch and redirect PC, and squashes the wrong-path fetch.
- Queues predictor training updates in a small FIFO drained by a valid/ready handshake. Keeps branch and mispredict statistics.

Parameters:
PC_W, 8, PC / target width
PC_STEP, 1, fall-through increment (word-addressed PC)
QDEPTH, 4, update FIFO entries (power of two, >=2)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
PC_IF  in  PC_W  PC of instruction in IF
PC_pre_IF  in  PC_W  predicted target
taken_IF  in  1  predicted taken
hit_IF  in  1  predictor tag hit
FD_stall  in  1  IF/ID hold
inst_valid  in  1  ID instruction valid
is_branch_ID  in  1  ID instruction is branch/jump
Branch_ctrl_ID  in  1  resolved taken
jump_PC_ID  in  PC_W  resolved target
refetch  out  1  mispredict, redirect fetch this cycle
redirect_PC  out  PC_W  fetch PC when refetch=1
upd_valid  out  1  update entry available
upd_PC  out  PC_W  branch PC
upd_taken  out  1  resolved direction
upd_target  out  PC_W  resolved target
upd_ready  in  1  predictor accepts update
upd_overflow  out  1  sticky: update dropped
branch_cnt  out  CNT_W  resolved branches
mispred_cnt  out  CNT_W  mispredictions

Behaviour:
- Reset (rst=0, async): ID regs, FIFO pointers/count, counters and upd_overflow cleared. All outputs 0. Reset mid-drain discards queued entries.
- ID regs PC_ID, pred_taken_ID, pred_tgt_ID, pred_hit_ID, valid_ID:
  - FD_stall=1: hold.
  - Else if refetch: load bubble (valid_ID=0, all fields 0).
  - Else: load IF values, valid_ID=1.
- resolve = valid_ID & inst_valid & is_branch_ID & ~FD_stall. Combinational in the ID cycle.
- mispredict = resolve & ((pred_taken_ID != Branch_ctrl_ID) | (pred_taken_ID & Branch_ctrl_ID & (pred_tgt_ID != jump_PC_ID))).
- refetch = mispredict (0 during stall).
- redirect_PC = jump_PC_ID if Branch_ctrl_ID, else PC_ID+PC_STEP (mod 2^PC_W). Value is 0 when refetch=0.
- Enqueue condition: enq = resolve & (Branch_ctrl_ID | pred_hit_ID). Not-taken misses are not trained. Entry = {PC_ID, Branch_ctrl_ID, jump_PC_ID}.
- FIFO: circular, pointers wrap mod QDEPTH.
  - Head drives upd_* directly (registered storage); upd_valid = count!=0.
  - deq = upd_valid & upd_ready.
  - upd_* hold stable while upd_valid & ~upd_ready.
- Full FIFO:
  - enq & deq in the same cycle: both occur, count unchanged.
  - enq while full & ~deq: entry dropped, upd_overflow set until reset.
- Empty FIFO: enq makes upd_valid=1 the next cycle; there is no bypass.
- Counters, updated at clock edge, saturating at 2^CNT_W-1:
  - branch_cnt += resolve.
  - mispred_cnt += mispredict.
- Back-to-back branches: the bubble after refetch guarantees the next resolve comes at the earliest 2 cycles later.

Test Plan:
1. Reset then release. IF PC_IF=0x10, hit=1, taken=1, PC_pre_IF=0x20. Next cycle ID branch, Branch_ctrl_ID=1, jump_PC_ID=0x20 -> refetch=0, branch_cnt=1, one FIFO entry {0x10,1,0x20}.
2. Predicted taken 0x20, resolved not-taken at PC_ID=0x10 -> refetch=1, redirect_PC=0x11, next ID valid_ID=0, mispred_cnt=1, entry {0x10,0,x}.
3. Predicted taken, target 0x20 vs actual 0x30 -> refetch=1, redirect_PC=0x30. Miss not-taken resolved not-taken -> no enqueue, refetch=0.
4. FD_stall=1 during mispredicting branch for 3 cycles -> refetch=0 and counters frozen. Stall drop -> refetch=1 exactly one cycle.
5. upd_ready=0, 5 enqueueing branches with QDEPTH=4 -> upd_overflow=1 after the 5th, upd_PC stays the first entry. Then upd_ready=1 -> 4 entries drain in order, upd_valid falls.
6. Assert rst=0 asynchronously mid-cycle with 3 queued entries -> upd_valid, refetch and counters 0 immediately, without waiting for a clock edge.
